// File: rtl/ascii_num_parser.sv
// ascii_num_parser: streams ASCII digits into an unsigned binary number.
// Define ASCII_NUM_PARSER_CR_EN to treat CR like LF as a line terminator.
module ascii_num_parser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [3:0]       out_ndigits,
  output logic             out_ovf,
  output logic             quit
);

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    DONE
  } state_t;

  localparam logic [WIDTH+3:0] TEN = (WIDTH+4)'(10);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [3:0]       cnt;
  logic             ovf;

  logic             take;
  logic             is_digit;
  logic             is_eol;
  logic [WIDTH+3:0] mac;
  logic             mac_ovf;

`ifdef ASCII_NUM_PARSER_CR_EN
  assign is_eol = (in_char == 8'h0A) || (in_char == 8'h0D);
`else
  assign is_eol = (in_char == 8'h0A);
`endif

  // byte classification and the widened multiply-add
  always_comb begin
    take     = in_valid && in_ready && (state == COLLECT);
    is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
    mac      = {4'b0, acc} * TEN
             + {{WIDTH{1'b0}}, in_char[3:0]};
    mac_ovf  = |mac[WIDTH+3:WIDTH];
  end

  // collect / emit / done sequencing with registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      quit      <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (take) begin
            if (is_digit) begin
              acc <= mac_ovf ? '1 : mac[WIDTH-1:0];
              ovf <= ovf | mac_ovf;
              if (cnt != 4'hF) cnt <= cnt + 4'd1;
            end else if (is_eol) begin
              if (cnt != 4'd0) begin
                state     <= EMIT;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
              end
            end else begin
              state    <= DONE;
              in_ready <= 1'b0;
              quit     <= 1'b1;
              acc      <= '0;
              cnt      <= '0;
              ovf      <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        DONE: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          quit      <= 1'b1;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign out_value   = acc;
  assign out_ndigits = cnt;
  assign out_ovf     = ovf;

endmodule

// File: tb/tb_ascii_num_parser.sv
// tb_ascii_num_parser: scoreboard bench for ascii_num_parser.
// Random digit lines plus directed overflow, backpressure, quit and reset cases.
module tb_ascii_num_parser;

  localparam int     W   = 16;
  localparam longint MAX = (64'd1 << W) - 1;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_char = 8'h00;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_value;
  logic [3:0]   out_ndigits;
  logic         out_ovf;
  logic         quit;

  ascii_num_parser #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_char     (in_char),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_ndigits (out_ndigits),
    .out_ovf     (out_ovf),
    .quit        (quit)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v;
    int     nd;
    bit     o;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     passed = 0;
  int     emits = 0;
  bit     rand_rdy = 1'b0;
  bit     stuck = 1'b0;
  longint m_val = 0;
  int     m_nd = 0;
  longint last_val = -1;
  longint last_nd = -1;
  longint last_ovf = -1;
  bit     pv = 1'b0;
  longint pval = 0;
  int     e0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference: the decimal value of the line, clipped at 2^W-1
  task automatic model_feed(input logic [7:0] c);
    exp_t e;
    bit   eol;
    eol = (c == LF);
`ifdef ASCII_NUM_PARSER_CR_EN
    if (c == CR) eol = 1'b1;
`endif
    if (c >= 8'h30 && c <= 8'h39) begin
      m_val = m_val * 10 + longint'(c - 8'h30);
      if (m_val > MAX) m_val = MAX + 1;
      m_nd++;
    end else if (eol) begin
      if (m_nd > 0) begin
        e.v  = (m_val > MAX) ? MAX : m_val;
        e.nd = (m_nd > 15) ? 15 : m_nd;
        e.o  = (m_val > MAX);
        q.push_back(e);
      end
      m_val = 0;
      m_nd  = 0;
    end else begin
      m_val = 0;
      m_nd  = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] c);
    int n;
    n = 0;
    if (stuck) begin
      chk("accept_skipped", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      stuck    = 1'b1;
      in_valid = 1'b0;
    end else begin
      model_feed(c);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    stuck    = 1'b0;
    q.delete();
    m_val = 0;
    m_nd  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_value", out_value, pval);
      end
      if (out_valid && out_ready) begin
        emits++;
        last_val = out_value;
        last_nd  = out_ndigits;
        last_ovf = out_ovf;
        if (q.size() == 0) begin
          chk("unexpected_emit", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("emit_value", out_value, mon_e.v);
          chk("emit_ndigits", out_ndigits, mon_e.nd);
          chk("emit_ovf", out_ovf, mon_e.o);
        end
      end
      pv   = out_valid && !out_ready;
      pval = out_value;
    end
  end

  always @(negedge clk)
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quit", quit, 0);
    chk("rst_value", out_value, 0);
    chk("rst_ndigits", out_ndigits, 0);
    chk("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", in_ready, 1);

    out_ready = 1'b1;
    e0 = emits;
    send_byte("4");
    send_byte("2");
    send_byte(LF);
    chk("v42_valid", out_valid, 1);
    chk("v42_value", out_value, 42);
    chk("v42_ndigits", out_ndigits, 2);
    chk("v42_ovf", out_ovf, 0);
    @(negedge clk);
    chk("v42_valid_one_cycle", out_valid, 0);
    chk("v42_in_ready", in_ready, 1);
    chk("v42_emits", emits - e0, 1);

    e0 = emits;
    send_byte(LF);
    send_byte(LF);
    send_byte("7");
    send_byte(LF);
    repeat (2) @(negedge clk);
    chk("blank_emits", emits - e0, 1);
    chk("blank_value", last_val, 7);

    send_byte("7");
    repeat (4) send_byte("0");
    send_byte(LF);
    @(negedge clk);
    chk("ovf_value", last_val, 64'hFFFF);
    chk("ovf_flag", last_ovf, 1);
    chk("ovf_ndigits", last_nd, 5);
    send_byte("1");
    send_byte(LF);
    @(negedge clk);
    chk("after_ovf_value", last_val, 1);
    chk("after_ovf_flag", last_ovf, 0);

    out_ready = 1'b0;
    send_byte("8");
    send_byte(LF);
    in_valid = 1'b1;
    in_char  = "9";
    repeat (5) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_value", out_value, 8);
      @(negedge clk);
    end
    e0 = emits;
    out_ready = 1'b1;
    send_byte("9");
    send_byte(LF);
    @(negedge clk);
    chk("bp_emits", emits - e0, 2);
    chk("bp_nine", last_val, 9);

    send_byte("1");
    send_byte("2");
    #3 rst_n = 1'b0;
    #1 chk("async_rst_value", out_value, 0);
    chk("async_rst_ndigits", out_ndigits, 0);
    do_reset();

    out_ready = 1'b0;
    send_byte("6");
    send_byte(LF);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_emit_valid", out_valid, 0);
    chk("async_rst_emit_value", out_value, 0);
    do_reset();
    chk("async_rst_in_ready", in_ready, 1);

    out_ready = 1'b1;
    e0 = emits;
    send_byte("3");
    send_byte("x");
    chk("quit_set", quit, 1);
    chk("quit_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_char  = "5";
    repeat (4) begin
      @(negedge clk);
      chk("done_in_ready", in_ready, 0);
      chk("done_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("quit_no_emit", emits - e0, 0);
    rst_n = 1'b0;
    #1 chk("quit_cleared", quit, 0);
    do_reset();
    chk("quit_rst_in_ready", in_ready, 1);

    e0 = emits;
    send_byte("5");
    send_byte(CR);
`ifdef ASCII_NUM_PARSER_CR_EN
    send_byte(LF);
    repeat (2) @(negedge clk);
    chk("cr_emits", emits - e0, 1);
    chk("cr_value", last_val, 5);
    chk("cr_in_ready", in_ready, 1);
`else
    chk("cr_quit", quit, 1);
    in_valid = 1'b1;
    in_char  = LF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("cr_no_emit", emits - e0, 0);
    chk("cr_in_ready", in_ready, 0);
    do_reset();
`endif

    rand_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) nd = $urandom_range(0, 17);
      else nd = $urandom_range(0, 6);
      for (int d = 0; d < nd; d++)
        send_byte(8'h30 + 8'($urandom_range(0, 9)));
      send_byte(LF);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    nd = 0;
    while (q.size() > 0 && nd < 100) begin
      @(negedge clk);
      nd++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ascii_num_parser.md
ASCII_NUM_PARSER -- requirements
Module: ascii_num_parser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the output value width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning an ASCII byte is presented.
REQ-005 The block SHALL have port in_char, input, 8 bits, carrying the ASCII byte.
REQ-006 The block SHALL have port in_ready, output, 1 bit; a byte is accepted on any rising edge with in_valid and in_ready both high.
REQ-007 The block SHALL have port out_valid, output, 1 bit, meaning a parsed number is available.
REQ-008 The block SHALL have port out_ready, input, 1 bit, the consumer accept for the parsed number.
REQ-009 The block SHALL have port out_value, output, WIDTH bits, the unsigned binary value of the parsed number.
REQ-010 The block SHALL have port out_ndigits, output, 4 bits, the count of digits in the number, saturating at 15.
REQ-011 The block SHALL have port out_ovf, output, 1 bit, meaning the number exceeded 2^WIDTH-1.
REQ-012 The block SHALL have port quit, output, 1 bit, meaning a non-digit terminated the session.

Function
REQ-013 The block SHALL be a 3-state FSM: COLLECT (in_ready=1, out_valid=0), EMIT (in_ready=0, out_valid=1), DONE (in_ready=0, out_valid=0, quit=1).
REQ-014 In COLLECT, an accepted digit byte 0x30-0x39 SHALL update acc to acc*10 + (in_char-0x30) and increment the digit count, saturating at 15.
REQ-015 The multiply-add SHALL be computed WIDTH+4 bits wide; if the result exceeds 2^WIDTH-1, acc SHALL saturate to all ones and ovf SHALL set, staying set until the number is emitted.
REQ-016 In COLLECT, an accepted LF (0x0A) with count>0 SHALL move the FSM to EMIT, with out_valid high on the next cycle.
REQ-017 In EMIT, out_value, out_ndigits and out_ovf SHALL present the registered acc, count and ovf, held stable.
REQ-018 In COLLECT, an accepted LF with count==0 (blank line) SHALL be discarded with no state change.
REQ-019 In COLLECT, any other accepted byte SHALL move the FSM to DONE.
REQ-020 On entry to DONE, quit SHALL assert on the next cycle, and a partial number SHALL be discarded.
REQ-021 In EMIT, out_valid SHALL stay high until out_valid and out_ready are both high at a rising edge.
REQ-022 On that EMIT handshake, acc, count and ovf SHALL clear to 0 and the FSM SHALL return to COLLECT, with in_ready high on the next cycle.
REQ-023 DONE SHALL be terminal and left only by reset; in_valid SHALL be ignored while in DONE.
REQ-024 Input bytes presented while in_ready=0 SHALL NOT be consumed.
REQ-025 Throughput SHALL be one byte per cycle in COLLECT.
REQ-026 Latency SHALL be one cycle from LF acceptance to out_valid, and one cycle from the EMIT handshake to in_ready.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in COLLECT; acc, count and ovf SHALL be 0; out_valid=0, out_value=0, out_ndigits=0, out_ovf=0, quit=0; and in_ready SHALL be 0.
REQ-028 in_ready SHALL assert on the first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-number or during EMIT SHALL discard all state immediately, without waiting for a clock edge.

Configuration
REQ-030 The block SHALL be configured by the macro ASCII_NUM_PARSER_CR_EN.
REQ-031 With ASCII_NUM_PARSER_CR_EN defined, CR (0x0D) SHALL be treated identically to LF, so CR LF emits one number and the trailing LF is discarded as a blank line.
REQ-032 Without ASCII_NUM_PARSER_CR_EN defined, CR SHALL be treated as a non-digit and move the FSM to DONE.

Verification
REQ-033 The bench SHALL send '4','2',LF with out_ready=1, and SHALL check out_value=42, out_ndigits=2, out_ovf=0, with out_valid high exactly 1 cycle, then in_ready=1.
REQ-034 The bench SHALL send LF,LF,'7',LF, and SHALL check a single emit with out_value=7, with the blank lines producing no out_valid.
REQ-035 With WIDTH=16, the bench SHALL send '7','0','0','0','0',LF, and SHALL check out_value=16'hFFFF, out_ovf=1, out_ndigits=5; the next number '1',LF SHALL give out_value=1, out_ovf=0.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles during EMIT, and SHALL check that in_ready stays 0, out_value stays stable, a presented '9' is not consumed, and '9' is accepted after the handshake.
REQ-037 The bench SHALL send '3','x', and SHALL check that quit=1 the next cycle, no out_valid occurs, and in_ready stays 0 until reset, after which quit=0.
REQ-038 The bench SHALL send '5',CR,LF under both macro settings, and SHALL check: with the macro defined, one emit of 5; with it undefined, quit=1 and no emit.
